// File: rtl/gx4000_asic_lock_seq.sv
// gx4000_asic_lock_seq
// Plus/GX4000 ASIC lock/unlock sequence detector. Snoops CPU I/O writes to
// the CRTC select port and follows the sync/body/key/ack byte sequence.
// When the key is accepted, the block unlocks or relocks the ASIC register page.
// Optional debug counters are enabled by defining GX4000_LOCK_SEQ_DBG_EN.
// Without that macro, dbg_attempts and dbg_fail_idx read as zero.
//
// Strobe semantics: io_wr is a level. A write is taken once, on the first
// clock it is seen high after being low, when the port matches and plus_mode is set.
// Holding io_wr high for several clocks never produces a second accept.
// There is no back-pressure: every qualifying strobe is consumed.
// The FSM state and body index are always visible on seq_status.

module gx4000_asic_lock_seq #(
    parameter logic [7:0]            PORT_HI    = 8'hBC,
    parameter logic [7:0]            PORT_MASK  = 8'hFF,
    parameter int                    BODY_LEN   = 13,
    parameter logic [8*BODY_LEN-1:0] BODY_SEQ   = 104'hFF77B351A8D462399C462B158A,
    parameter logic [7:0]            UNLOCK_KEY = 8'hCD,
    parameter bit                    ACK_EN     = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        plus_mode,
    input  logic [15:0] io_addr,
    input  logic        io_wr,
    input  logic [7:0]  io_din,
    output logic        asic_unlocked,
    output logic        unlock_pulse,
    output logic        lock_pulse,
    output logic [7:0]  seq_status,
    output logic [15:0] dbg_attempts,
    output logic [4:0]  dbg_fail_idx
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SYNC = 3'd1;
    localparam logic [2:0] S_BODY = 3'd2;
    localparam logic [2:0] S_KEY  = 3'd3;
    localparam logic [2:0] S_ACK  = 3'd4;

    localparam logic [4:0] LAST_IDX = 5'(BODY_LEN - 1);
    localparam logic [2:0] AFTER_KEY = ACK_EN ? S_ACK : S_IDLE;

    logic [2:0] state;
    logic [4:0] idx;
    logic       wr_q;
    logic       port_hit;
    logic       accept;
    logic [7:0] body_byte;
    logic [7:0] body_tbl [32];
    logic       unused_addr_lo;

    // The low address byte is not decoded; only the high byte selects the port.
    assign unused_addr_lo = ^io_addr[7:0];

    // Unpack the body bytes into a table, with the first byte at index 0.
    // Unused entries are padded so that any 5-bit index is in range.
    for (genvar i = 0; i < 32; i++) begin : g_tbl
        if (i < BODY_LEN) begin : g_used
            assign body_tbl[i] = BODY_SEQ[8*(BODY_LEN-1-i) +: 8];
        end else begin : g_pad
            assign body_tbl[i] = 8'h00;
        end
    end

    assign body_byte  = body_tbl[idx];
    assign port_hit   = ((io_addr[15:8] ^ PORT_HI) & PORT_MASK) == 8'h00;
    assign accept     = plus_mode && io_wr && !wr_q && port_hit;
    assign seq_status = {state, idx};

    // Remember the previous strobe level so that one strobe gives one accept.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= 1'b0;
        end else begin
            wr_q <= io_wr;
        end
    end

    // Sequence FSM, lock state and the one-clock result pulses.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            idx           <= 5'd0;
            asic_unlocked <= 1'b0;
            unlock_pulse  <= 1'b0;
            lock_pulse    <= 1'b0;
        end else begin
            unlock_pulse <= 1'b0;
            lock_pulse   <= 1'b0;
            if (!plus_mode) begin
                state         <= S_IDLE;
                idx           <= 5'd0;
                asic_unlocked <= 1'b0;
            end else if (accept) begin
                case (state)
                    S_IDLE: begin
                        if (io_din != 8'h00) state <= S_SYNC;
                    end
                    S_SYNC: begin
                        if (io_din == 8'h00) begin
                            state <= S_BODY;
                            idx   <= 5'd0;
                        end
                    end
                    S_BODY: begin
                        if (io_din == body_byte) begin
                            if (idx == LAST_IDX) begin
                                state <= S_KEY;
                                idx   <= 5'd0;
                            end else begin
                                idx <= idx + 5'd1;
                            end
                        end else begin
                            state <= (io_din != 8'h00) ? S_SYNC : S_IDLE;
                            idx   <= 5'd0;
                        end
                    end
                    S_KEY: begin
                        if (io_din == UNLOCK_KEY) begin
                            asic_unlocked <= 1'b1;
                            unlock_pulse  <= 1'b1;
                        end else begin
                            asic_unlocked <= 1'b0;
                            lock_pulse    <= 1'b1;
                        end
                        state <= AFTER_KEY;
                    end
                    S_ACK: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        idx   <= 5'd0;
                    end
                endcase
            end
        end
    end

`ifdef GX4000_LOCK_SEQ_DBG_EN
    logic enter_body;
    logic body_miss;

    assign enter_body = accept && (state == S_SYNC) && (io_din == 8'h00);
    assign body_miss  = accept && (state == S_BODY) && (io_din != body_byte);

    // Debug counters; they survive plus_mode=0 and clear only on reset.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dbg_attempts <= 16'h0000;
            dbg_fail_idx <= 5'd0;
        end else begin
            if (enter_body && dbg_attempts != 16'hFFFF) dbg_attempts <= dbg_attempts + 16'd1;
            if (body_miss) dbg_fail_idx <= idx;
        end
    end
`else
    assign dbg_attempts = 16'h0000;
    assign dbg_fail_idx = 5'd0;
`endif

endmodule

// File: tb/tb_gx4000_asic_lock_seq.sv
// tb_gx4000_asic_lock_seq
// Directed bench for the lock sequence detector. It uses two instances:
// the default configuration, and a short one (2-byte body, no ack byte).
// The debug checks follow GX4000_LOCK_SEQ_DBG_EN.

module tb_gx4000_asic_lock_seq;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        plus_mode = 1'b1;
    logic [15:0] io_addr = 16'h0000;
    logic        io_wr = 1'b0;
    logic [7:0]  io_din = 8'h00;

    logic        asic_unlocked, unlock_pulse, lock_pulse;
    logic [7:0]  seq_status;
    logic [15:0] dbg_attempts;
    logic [4:0]  dbg_fail_idx;

    logic        s_unlocked, s_unlock_pulse, s_lock_pulse;
    logic [7:0]  s_status;
    logic [15:0] s_attempts;
    logic [4:0]  s_fail_idx;

    int n_checks = 0;
    int n_fail = 0;
    int n_unl = 0;
    int n_lck = 0;
    logic snap_u, snap_l, snap_su;
    int base_u, base_l;

    logic [7:0] body_b [13] = '{8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62,
                                8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A};

    gx4000_asic_lock_seq dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .plus_mode(plus_mode),
        .io_addr(io_addr), .io_wr(io_wr), .io_din(io_din),
        .asic_unlocked(asic_unlocked), .unlock_pulse(unlock_pulse), .lock_pulse(lock_pulse),
        .seq_status(seq_status), .dbg_attempts(dbg_attempts), .dbg_fail_idx(dbg_fail_idx)
    );

    gx4000_asic_lock_seq #(
        .BODY_LEN(2), .BODY_SEQ(16'hA55A), .UNLOCK_KEY(8'h42), .ACK_EN(1'b0)
    ) dut_s (
        .clk_sys(clk_sys), .reset_n(reset_n), .plus_mode(plus_mode),
        .io_addr(io_addr), .io_wr(io_wr), .io_din(io_din),
        .asic_unlocked(s_unlocked), .unlock_pulse(s_unlock_pulse), .lock_pulse(s_lock_pulse),
        .seq_status(s_status), .dbg_attempts(s_attempts), .dbg_fail_idx(s_fail_idx)
    );

    // Clock and reset
    always #5 clk_sys = ~clk_sys;

    // Count pulse-high clocks; a stretched pulse shows up as an extra count
    always @(negedge clk_sys) begin
        if (unlock_pulse) n_unl++;
        if (lock_pulse) n_lck++;
    end

    task automatic do_reset();
        io_wr = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        @(posedge clk_sys);
        #1;
    endtask

    // One strobe held for 'hold' clocks, then one low clock. The pulses are
    // captured just after the accepting edge.
    task automatic wr(input logic [15:0] a, input logic [7:0] d, input int hold);
        io_addr = a;
        io_din = d;
        io_wr = 1'b1;
        @(posedge clk_sys);
        #1;
        snap_u = unlock_pulse;
        snap_l = lock_pulse;
        snap_su = s_unlock_pulse;
        if (hold > 1) begin
            repeat (hold - 1) @(posedge clk_sys);
            #1;
        end
        io_wr = 1'b0;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_body(input int from, input int to);
        for (int i = from; i < to; i++) wr(16'hBC00, body_b[i], 1);
    endtask

    task automatic full_seq(input logic [7:0] key);
        wr(16'hBC00, 8'h01, 1);
        wr(16'hBC00, 8'h00, 1);
        send_body(0, 13);
        wr(16'hBC00, key, 1);
        wr(16'hBC00, 8'hEE, 1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        n_checks++; if (asic_unlocked !== 1'b0) begin n_fail++; $display("FAIL reset_unlocked got %b want 0", asic_unlocked); end
        n_checks++; if ({unlock_pulse, lock_pulse} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got %b want 00", {unlock_pulse, lock_pulse}); end
        n_checks++; if (seq_status !== 8'h00) begin n_fail++; $display("FAIL reset_status got %h want 00", seq_status); end
        n_checks++; if ({dbg_attempts, dbg_fail_idx} !== 21'd0) begin n_fail++; $display("FAIL reset_dbg got %h/%h want 0/0", dbg_attempts, dbg_fail_idx); end
        n_checks++; if ({s_unlocked, s_status} !== 9'd0) begin n_fail++; $display("FAIL reset_small got %b/%h want 0/00", s_unlocked, s_status); end
        do_reset();
    endtask

    task automatic test_unlock();
        base_u = n_unl; base_l = n_lck;
        wr(16'hBC00, 8'h01, 1);
        n_checks++; if (seq_status !== 8'h20) begin n_fail++; $display("FAIL unl_sync got %h want 20", seq_status); end
        wr(16'hBC00, 8'h00, 1);
        n_checks++; if (seq_status !== 8'h40) begin n_fail++; $display("FAIL unl_body0 got %h want 40", seq_status); end
        send_body(0, 3);
        n_checks++; if (seq_status !== 8'h43) begin n_fail++; $display("FAIL unl_body3 got %h want 43", seq_status); end
        send_body(3, 13);
        n_checks++; if (seq_status !== 8'h60) begin n_fail++; $display("FAIL unl_key got %h want 60", seq_status); end
        wr(16'hBC00, 8'hCD, 1);
        n_checks++; if (snap_u !== 1'b1) begin n_fail++; $display("FAIL unl_pulse_time got %b want 1", snap_u); end
        n_checks++; if (asic_unlocked !== 1'b1) begin n_fail++; $display("FAIL unl_state got %b want 1", asic_unlocked); end
        n_checks++; if (seq_status !== 8'h80) begin n_fail++; $display("FAIL unl_ack got %h want 80", seq_status); end
        wr(16'hBC00, 8'hEE, 1);
        n_checks++; if (seq_status !== 8'h00) begin n_fail++; $display("FAIL unl_idle got %h want 00", seq_status); end
        n_checks++; if (asic_unlocked !== 1'b1) begin n_fail++; $display("FAIL unl_persist got %b want 1", asic_unlocked); end
        n_checks++; if ((n_unl - base_u) !== 1 || (n_lck - base_l) !== 0) begin n_fail++; $display("FAIL unl_pulse_count got %0d/%0d want 1/0", n_unl - base_u, n_lck - base_l); end
    endtask

    task automatic test_lock();
        base_u = n_unl; base_l = n_lck;
        full_seq(8'h00);
        n_checks++; if (asic_unlocked !== 1'b0) begin n_fail++; $display("FAIL lock_state got %b want 0", asic_unlocked); end
        n_checks++; if ((n_lck - base_l) !== 1 || (n_unl - base_u) !== 0) begin n_fail++; $display("FAIL lock_pulse_count got %0d/%0d want 1/0", n_lck - base_l, n_unl - base_u); end
        // relock while already locked still pulses
        base_l = n_lck;
        wr(16'hBC00, 8'h01, 1);
        wr(16'hBC00, 8'h00, 1);
        send_body(0, 13);
        wr(16'hBC00, 8'h11, 1);
        n_checks++; if (snap_l !== 1'b1) begin n_fail++; $display("FAIL relock_pulse got %b want 1", snap_l); end
        wr(16'hBC00, 8'hEE, 1);
        n_checks++; if ((n_lck - base_l) !== 1 || asic_unlocked !== 1'b0) begin n_fail++; $display("FAIL relock_state got %0d/%b want 1/0", n_lck - base_l, asic_unlocked); end
    endtask

    task automatic test_mismatch();
        do_reset();
        wr(16'hBC00, 8'h01, 1);
        wr(16'hBC00, 8'h00, 1);
        wr(16'hBC00, 8'hFF, 1);
        wr(16'hBC00, 8'h77, 1);
        wr(16'hBC00, 8'h55, 1);
        n_checks++; if (seq_status !== 8'h20) begin n_fail++; $display("FAIL miss_sync got %h want 20", seq_status); end
`ifdef GX4000_LOCK_SEQ_DBG_EN
        n_checks++; if (dbg_fail_idx !== 5'd2) begin n_fail++; $display("FAIL miss_dbg_idx got %0d want 2", dbg_fail_idx); end
`else
        n_checks++; if (dbg_fail_idx !== 5'd0) begin n_fail++; $display("FAIL miss_dbg_idx got %0d want 0", dbg_fail_idx); end
`endif
        wr(16'hBC00, 8'h00, 1);
        send_body(0, 13);
        wr(16'hBC00, 8'hCD, 1);
        n_checks++; if (asic_unlocked !== 1'b1) begin n_fail++; $display("FAIL miss_recover got %b want 1", asic_unlocked); end
        wr(16'hBC00, 8'hEE, 1);
`ifdef GX4000_LOCK_SEQ_DBG_EN
        n_checks++; if (dbg_attempts !== 16'd2) begin n_fail++; $display("FAIL miss_attempts got %0d want 2", dbg_attempts); end
`else
        n_checks++; if (dbg_attempts !== 16'd0) begin n_fail++; $display("FAIL miss_attempts got %0d want 0", dbg_attempts); end
`endif
        // a zero mismatch falls back to IDLE
        wr(16'hBC00, 8'h01, 1);
        wr(16'hBC00, 8'h00, 1);
        wr(16'hBC00, 8'hFF, 1);
        wr(16'hBC00, 8'h00, 1);
        n_checks++; if (seq_status !== 8'h00) begin n_fail++; $display("FAIL miss_zero_idle got %h want 00", seq_status); end
    endtask

    task automatic test_long_strobe();
        do_reset();
        base_u = n_unl;
        wr(16'hBC00, 8'h01, 5);
        n_checks++; if (seq_status !== 8'h20) begin n_fail++; $display("FAIL long_sync got %h want 20", seq_status); end
        wr(16'hBC00, 8'h00, 5);
        n_checks++; if (seq_status !== 8'h40) begin n_fail++; $display("FAIL long_body got %h want 40", seq_status); end
        send_body(0, 5);
        wr(16'hBD00, 8'h00, 1);
        n_checks++; if (seq_status !== 8'h45) begin n_fail++; $display("FAIL other_port got %h want 45", seq_status); end
        send_body(5, 13);
        wr(16'hBC00, 8'hCD, 4);
        wr(16'hBC00, 8'hEE, 1);
        n_checks++; if (asic_unlocked !== 1'b1 || (n_unl - base_u) !== 1) begin n_fail++; $display("FAIL long_unlock got %b/%0d want 1/1", asic_unlocked, n_unl - base_u); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        full_seq(8'hCD);
        wr(16'hBC00, 8'h01, 1);
        wr(16'hBC00, 8'h00, 1);
        send_body(0, 7);
        n_checks++; if (seq_status !== 8'h47) begin n_fail++; $display("FAIL rmid_idx got %h want 47", seq_status); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if ({asic_unlocked, seq_status} !== 9'd0) begin n_fail++; $display("FAIL rmid_async got %b/%h want 0/00", asic_unlocked, seq_status); end
        @(posedge clk_sys);
        #1 reset_n = 1'b1;
        @(posedge clk_sys);
        #1;
        base_u = n_unl;
        send_body(7, 13);
        wr(16'hBC00, 8'hCD, 1);
        n_checks++; if (seq_status !== 8'h20 || asic_unlocked !== 1'b0 || (n_unl - base_u) !== 0) begin n_fail++; $display("FAIL rmid_no_resume got %h/%b/%0d want 20/0/0", seq_status, asic_unlocked, n_unl - base_u); end
        n_checks++; if (dbg_attempts !== 16'd0) begin n_fail++; $display("FAIL rmid_attempts got %0d want 0", dbg_attempts); end
    endtask

    task automatic test_plus_mode();
        do_reset();
        full_seq(8'hCD);
        plus_mode = 1'b0;
        @(posedge clk_sys);
        #1;
        n_checks++; if (asic_unlocked !== 1'b0) begin n_fail++; $display("FAIL pm_lock got %b want 0", asic_unlocked); end
        plus_mode = 1'b1;
        wr(16'hBC00, 8'h01, 1);
        wr(16'hBC00, 8'h00, 1);
        plus_mode = 1'b0;
        base_l = n_lck; base_u = n_unl;
        wr(16'hBC00, 8'h01, 1);
        n_checks++; if (seq_status !== 8'h00) begin n_fail++; $display("FAIL pm_idle got %h want 00", seq_status); end
        plus_mode = 1'b1;
        wr(16'hBC00, 8'h00, 1);
        n_checks++; if (seq_status !== 8'h00 || (n_lck - base_l) !== 0 || (n_unl - base_u) !== 0) begin n_fail++; $display("FAIL pm_restart got %h/%0d/%0d want 00/0/0", seq_status, n_lck - base_l, n_unl - base_u); end
    endtask

    task automatic test_small_cfg();
        do_reset();
        wr(16'hBC00, 8'h07, 1);
        wr(16'hBC00, 8'h00, 1);
        wr(16'hBC00, 8'hA5, 1);
        wr(16'hBC00, 8'h5A, 1);
        n_checks++; if (s_status !== 8'h60) begin n_fail++; $display("FAIL small_key got %h want 60", s_status); end
        wr(16'hBC00, 8'h42, 1);
        n_checks++; if (snap_su !== 1'b1 || s_unlocked !== 1'b1) begin n_fail++; $display("FAIL small_unlock got %b/%b want 1/1", snap_su, s_unlocked); end
        n_checks++; if (s_status !== 8'h00) begin n_fail++; $display("FAIL small_idle got %h want 00", s_status); end
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_lock();
        test_mismatch();
        test_long_strobe();
        test_reset_mid();
        test_plus_mode();
        test_small_cfg();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
